iterative_shift_unit: RTL

Multi-cycle, parametrised shift engine for the MIPS datapath. It generalises the fixed left-shift-by-2 branch-offset block to four modes (SLL, SRL, SRA, ROTR) and a runtime shift amount. It shifts up to STEP bits per clock under a start/busy/done handshake. It serves the shift instructions (sll/srl/sra/sllv/srlv/srav) and branch-offset generation (SLL by 2) without a full combinational barrel shifter.

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_step.sv | 35 +++
 rtl/iterative_shift_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types for the iterative shift unit
package shift_pkg;

  // Shift operation selected with start and held for the whole operation.
  typedef enum logic [1:0] {
    SLL  = 2'd0,
    SRL  = 2'd1,
    SRA  = 2'd2,
    ROTR = 2'd3
  } shift_mode_t;

  // Control states of the multi-cycle engine.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shifter (0..STEP bits)
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int AMT_W = $clog2(STEP + 1)
) (
  input  shift_mode_t      mode,
  input  logic [WIDTH-1:0] data,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] result
);

  // One bit wider than a shift count so that WIDTH itself is representable.
  localparam int BACK_W = $clog2(WIDTH) + 1;

  // Left-shift distance that brings the bits dropped off the LSB back in at the MSB.
  // With amt = 0 this equals WIDTH, which shifts everything out and leaves data untouched.
  logic [BACK_W-1:0] back_amt;

  // Select the shifted value for the requested mode.
  always_comb begin
    back_amt = BACK_W'(WIDTH) - BACK_W'(amt);
    result   = data;
    case (mode)
      SLL:     result = data << amt;
      SRL:     result = data >> amt;
      SRA:     result = $unsigned($signed(data) >>> amt);
      ROTR:    result = (data >> amt) | (data << back_amt);
      default: result = data;
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// rtl/iterative_shift_unit.sv - multi-cycle SLL/SRL/SRA/ROTR engine, up to STEP bits per clock
module iterative_shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  shift_mode_t        mode,
  input  logic [WIDTH-1:0]   dataIn,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   dataOut
);

  localparam int AMT_W = $clog2(STEP + 1);
  // Remaining count widened by one bit so STEP (which may equal WIDTH) compares cleanly.
  localparam int CNT_W = SHAMT_W + 1;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  state_t             state_q;
  state_t             state_d;
  shift_mode_t        mode_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [SHAMT_W-1:0] rem_next;
  logic [CNT_W-1:0]   rem_ext;
  logic [AMT_W-1:0]   amt;
  logic               last_step;
  logic               accept;
  logic               shift_en;
  logic [WIDTH-1:0]   step_result;

  // Size of this cycle's step: a full STEP, or whatever is left on the final step.
  always_comb begin
    rem_ext   = {1'b0, rem_q};
    last_step = (rem_ext <= STEP_C);
    amt       = last_step ? AMT_W'(rem_q) : AMT_W'(STEP);
    rem_next  = rem_q - SHAMT_W'(amt);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .mode   (mode_q),
    .data   (dataOut),
    .amt    (amt),
    .result (step_result)
  );

  // Next-state logic: new work is accepted from IDLE or DONE, never while shifting.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          accept  = 1'b1;
          state_d = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_step) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with busy/done registered from the next state so outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == SHIFT);
      done    <= (state_d == DONE);
    end
  end

  // Operand capture on acceptance, then one partial shift per cycle until the count runs out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataOut <= '0;
      mode_q  <= SLL;
      rem_q   <= '0;
    end else if (accept) begin
      dataOut <= dataIn;
      mode_q  <= mode;
      rem_q   <= shamt;
    end else if (shift_en) begin
      dataOut <= step_result;
      rem_q   <= rem_next;
    end
  end

endmodule
